// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side controller of the asynchronous FIFO, entirely in
// the R_CLK domain. Synchronises the Gray write pointer, derives EMPTY and
// LEVEL, drives the memory read address, publishes the Gray read pointer
// back to the write side, and holds one word in a registered output stage
// with a VALID/READY handshake.
//
// Ports:
//   R_CLK        read-domain clock (rising edge)
//   R_RST        synchronous active-high reset
//   WQ_PTR_GRAY  write pointer, Gray, asynchronous to R_CLK
//   MEM_RD_DATA  combinational memory read data at R_ADDR
//   DOUT_READY   downstream accepts DOUT this cycle
//   R_ADDR       memory read address (low bits of the binary read pointer)
//   RD_PTR_GRAY  registered Gray read pointer for the write-side synchroniser
//   EMPTY        no unread word in memory as seen from the read domain
//   LEVEL        words in memory, excluding the output stage
//   DOUT         output data register
//   DOUT_VALID   DOUT holds a valid word
module fifo_rd_ctrl #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  R_CLK,
  input  logic                  R_RST,
  input  logic [ADDR_WIDTH:0]   WQ_PTR_GRAY,
  input  logic [DATA_WIDTH-1:0] MEM_RD_DATA,
  input  logic                  DOUT_READY,
  output logic [ADDR_WIDTH-1:0] R_ADDR,
  output logic [ADDR_WIDTH:0]   RD_PTR_GRAY,
  output logic                  EMPTY,
  output logic [ADDR_WIDTH:0]   LEVEL,
  output logic [DATA_WIDTH-1:0] DOUT,
  output logic                  DOUT_VALID
);

  localparam int PTR_W = ADDR_WIDTH + 1;

  logic [PTR_W-1:0]      sync_q [SYNC_STAGES];
  logic [PTR_W-1:0]      wq_sync;
  logic [PTR_W-1:0]      wbin_sync;
  logic [PTR_W-1:0]      rptr_bin;
  logic [PTR_W-1:0]      next_bin;
  logic [PTR_W-1:0]      rd_gray_q;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  dout_valid_q;
  logic                  empty;
  logic                  pop;

  // Write-pointer synchroniser: the only consumer of WQ_PTR_GRAY.
  always_ff @(posedge R_CLK) begin
    if (R_RST) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= WQ_PTR_GRAY;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign wq_sync = sync_q[SYNC_STAGES-1];

  // Gray to binary: bit i is the XOR of all Gray bits from i up to the MSB.
  always_comb begin
    wbin_sync = '0;
    for (int unsigned i = 0; i < PTR_W; i++) begin
      wbin_sync[i] = ^(wq_sync >> i);
    end
  end

  // Compared in Gray against the registered read pointer so EMPTY is a
  // function of flops only.
  assign empty    = (rd_gray_q == wq_sync);
  assign pop      = !empty && (!dout_valid_q || DOUT_READY);
  assign next_bin = rptr_bin + PTR_W'(1);

  always_ff @(posedge R_CLK) begin
    if (R_RST) begin
      rptr_bin     <= '0;
      rd_gray_q    <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else if (pop) begin
      rptr_bin     <= next_bin;
      rd_gray_q    <= next_bin ^ (next_bin >> 1);
      dout_q       <= MEM_RD_DATA;
      dout_valid_q <= 1'b1;
    end else if (dout_valid_q && DOUT_READY) begin
      dout_valid_q <= 1'b0;
    end
  end

  assign R_ADDR      = rptr_bin[ADDR_WIDTH-1:0];
  assign RD_PTR_GRAY = rd_gray_q;
  assign EMPTY       = empty;
  assign LEVEL       = wbin_sync - rptr_bin;
  assign DOUT        = dout_q;
  assign DOUT_VALID  = dout_valid_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
module tb_fifo_rd_ctrl;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int SS = 2;
  localparam int PW = AW + 1;

  logic          R_CLK;
  logic          R_RST;
  logic [PW-1:0] WQ_PTR_GRAY;
  logic [DW-1:0] MEM_RD_DATA;
  logic          DOUT_READY;
  logic [AW-1:0] R_ADDR;
  logic [PW-1:0] RD_PTR_GRAY;
  logic          EMPTY;
  logic [PW-1:0] LEVEL;
  logic [DW-1:0] DOUT;
  logic          DOUT_VALID;

  logic [DW-1:0] mem [8];
  assign MEM_RD_DATA = mem[R_ADDR];

  fifo_rd_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SYNC_STAGES(SS)) dut (
    .R_CLK(R_CLK), .R_RST(R_RST), .WQ_PTR_GRAY(WQ_PTR_GRAY),
    .MEM_RD_DATA(MEM_RD_DATA), .DOUT_READY(DOUT_READY), .R_ADDR(R_ADDR),
    .RD_PTR_GRAY(RD_PTR_GRAY), .EMPTY(EMPTY), .LEVEL(LEVEL), .DOUT(DOUT),
    .DOUT_VALID(DOUT_VALID)
  );

  initial R_CLK = 1'b0;
  always #5 R_CLK = ~R_CLK;

  int unsigned cmp_cnt = 0;
  int unsigned err_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] gray(input int unsigned n);
    logic [PW-1:0] b;
    b = PW'(n % 16);
    return b ^ (b >> 1);
  endfunction

  // Directed vector table
  typedef struct {
    logic          rst;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [PW-1:0] wq;
    logic          rdy;
    logic          e_empty;
    logic          e_valid;
    logic [DW-1:0] e_dout;
    logic [PW-1:0] e_level;
    logic [AW-1:0] e_raddr;
    logic [PW-1:0] e_rgray;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic we, input int wa, input int wd,
                              input int wq, input logic rdy, input logic e_empty,
                              input logic e_valid, input int e_dout, input int e_level,
                              input int e_raddr, input int e_rgray);
    vec_t v;
    v.rst = rst; v.we = we; v.wa = AW'(wa); v.wd = DW'(wd); v.wq = PW'(wq); v.rdy = rdy;
    v.e_empty = e_empty; v.e_valid = e_valid; v.e_dout = DW'(e_dout);
    v.e_level = PW'(e_level); v.e_raddr = AW'(e_raddr); v.e_rgray = PW'(e_rgray);
    return v;
  endfunction

  // Behavioural reference: counts of words written/read, a delay line of
  // advertised write counts, and a log of written data by absolute index.
  int unsigned   wr_cnt;
  int unsigned   m_rd;
  logic          m_valid;
  logic [DW-1:0] m_dout;
  int unsigned   hist[$];
  logic [DW-1:0] log_mem [4096];
  logic          last_pop;

  task automatic cycle(input logic rst, input logic rdy, input logic wr_req, input logic [DW-1:0] wd);
    int unsigned vis;
    logic        do_pop;
    if (rst) begin
      wr_cnt = 0;
    end else if (wr_req && (wr_cnt - m_rd < 8)) begin
      mem[wr_cnt % 8] = wd;
      log_mem[wr_cnt % 4096] = wd;
      wr_cnt++;
    end
    vis    = hist[0];
    do_pop = !rst && (vis != m_rd) && (!m_valid || rdy);
    R_RST       = rst;
    DOUT_READY  = rdy;
    WQ_PTR_GRAY = gray(wr_cnt);
    @(posedge R_CLK);
    #1;
    last_pop = do_pop;
    if (rst) begin
      m_rd = 0; m_valid = 1'b0; m_dout = '0;
      hist = {};
      for (int i = 0; i < SS; i++) hist.push_back(0);
    end else begin
      hist.push_back(wr_cnt);
      void'(hist.pop_front());
      if (do_pop) begin
        m_dout  = log_mem[m_rd % 4096];
        m_valid = 1'b1;
        m_rd++;
      end else if (m_valid && rdy) begin
        m_valid = 1'b0;
      end
    end
    check("model EMPTY", 32'(EMPTY), 32'(hist[0] == m_rd));
    check("model LEVEL", 32'(LEVEL), hist[0] - m_rd);
    check("model DOUT_VALID", 32'(DOUT_VALID), 32'(m_valid));
    check("model DOUT", 32'(DOUT), 32'(m_dout));
    check("model R_ADDR", 32'(R_ADDR), m_rd % 8);
    check("model RD_PTR_GRAY", 32'(RD_PTR_GRAY), 32'(gray(m_rd)));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[16];
    int   popped;
    int   first_pop_cyc;
    int   last_pop_cyc;
    logic reached;

    R_RST = 1'b1; WQ_PTR_GRAY = '0; DOUT_READY = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = '0;

    //            rst we wa  wd    wq  rdy | emp val dout  lvl ra gray
    tbl[0]  = mk(1, 0, 0, 8'h00, 0, 1,   1, 0, 8'h00, 0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 8'hA5, 1, 1,   1, 0, 8'h00, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 8'h00, 1, 1,   0, 0, 8'h00, 1, 0, 0);
    tbl[3]  = mk(0, 0, 0, 8'h00, 1, 1,   1, 1, 8'hA5, 0, 1, 1);
    tbl[4]  = mk(0, 0, 0, 8'h00, 1, 1,   1, 0, 8'hA5, 0, 1, 1);
    tbl[5]  = mk(1, 0, 0, 8'h00, 0, 0,   1, 0, 8'h00, 0, 0, 0);
    tbl[6]  = mk(0, 1, 0, 8'h11, 0, 0,   1, 0, 8'h00, 0, 0, 0);
    tbl[7]  = mk(0, 1, 1, 8'h22, 0, 0,   1, 0, 8'h00, 0, 0, 0);
    tbl[8]  = mk(0, 1, 2, 8'h33, 2, 0,   1, 0, 8'h00, 0, 0, 0);
    tbl[9]  = mk(0, 0, 0, 8'h00, 2, 0,   0, 0, 8'h00, 3, 0, 0);
    tbl[10] = mk(0, 0, 0, 8'h00, 2, 0,   0, 1, 8'h11, 2, 1, 1);
    tbl[11] = mk(0, 0, 0, 8'h00, 2, 0,   0, 1, 8'h11, 2, 1, 1);
    tbl[12] = mk(0, 0, 0, 8'h00, 2, 0,   0, 1, 8'h11, 2, 1, 1);
    tbl[13] = mk(0, 0, 0, 8'h00, 2, 1,   0, 1, 8'h22, 1, 2, 3);
    tbl[14] = mk(0, 0, 0, 8'h00, 2, 1,   1, 1, 8'h33, 0, 3, 2);
    tbl[15] = mk(0, 0, 0, 8'h00, 2, 1,   1, 0, 8'h33, 0, 3, 2);

    for (int i = 0; i < 16; i++) begin
      R_RST = tbl[i].rst;
      if (tbl[i].we) mem[tbl[i].wa] = tbl[i].wd;
      WQ_PTR_GRAY = tbl[i].wq;
      DOUT_READY  = tbl[i].rdy;
      @(posedge R_CLK);
      #1;
      check($sformatf("tbl[%0d] EMPTY", i), 32'(EMPTY), 32'(tbl[i].e_empty));
      check($sformatf("tbl[%0d] DOUT_VALID", i), 32'(DOUT_VALID), 32'(tbl[i].e_valid));
      check($sformatf("tbl[%0d] DOUT", i), 32'(DOUT), 32'(tbl[i].e_dout));
      check($sformatf("tbl[%0d] LEVEL", i), 32'(LEVEL), 32'(tbl[i].e_level));
      check($sformatf("tbl[%0d] R_ADDR", i), 32'(R_ADDR), 32'(tbl[i].e_raddr));
      check($sformatf("tbl[%0d] RD_PTR_GRAY", i), 32'(RD_PTR_GRAY), 32'(tbl[i].e_rgray));
    end

    // Streaming 16 words through a full pointer wrap
    cycle(1'b1, 1'b1, 1'b0, 8'h00);
    popped = 0; first_pop_cyc = -1; last_pop_cyc = -1;
    for (int c = 0; c < 60 && popped < 16; c++) begin
      cycle(1'b0, 1'b1, wr_cnt < 16, 8'(wr_cnt));
      if (last_pop) begin
        check("stream order DOUT", 32'(DOUT), 32'(popped));
        if (first_pop_cyc < 0) first_pop_cyc = c;
        last_pop_cyc = c;
        popped++;
        if (popped == 8) begin
          check("stream gray after 8 pops", 32'(RD_PTR_GRAY), 32'h0000000C);
          check("stream R_ADDR wrap", 32'(R_ADDR), 32'd0);
        end
        if (popped == 16) check("stream gray after 16 pops", 32'(RD_PTR_GRAY), 32'd0);
      end
    end
    check("stream pop count", 32'(popped), 32'd16);
    check("stream no bubble", 32'(last_pop_cyc - first_pop_cyc), 32'd15);

    // Full view: eight words advertised at once against rptr_bin = 0
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      mem[i] = 8'(8'h80 + i);
      log_mem[i] = 8'(8'h80 + i);
    end
    wr_cnt = 8;
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    check("full EMPTY after 1 edge", 32'(EMPTY), 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 8'h00);
    check("full LEVEL", 32'(LEVEL), 32'd8);
    check("full EMPTY after 2 edges", 32'(EMPTY), 32'd0);
    for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, 1'b0, 8'h00);
    check("full drained", 32'(m_rd), 32'd8);

    // Reset while the output stage is occupied and LEVEL = 3
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    reached = 1'b0;
    for (int c = 0; c < 12 && !reached; c++) begin
      cycle(1'b0, 1'b0, wr_cnt < 4, 8'($urandom));
      if (m_valid && (hist[0] - m_rd == 3)) reached = 1'b1;
    end
    check("midrst precondition reached", 32'(reached), 32'd1);
    check("midrst pre DOUT_VALID", 32'(DOUT_VALID), 32'd1);
    check("midrst pre LEVEL", 32'(LEVEL), 32'd3);
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    check("midrst DOUT_VALID", 32'(DOUT_VALID), 32'd0);
    check("midrst LEVEL", 32'(LEVEL), 32'd0);
    check("midrst RD_PTR_GRAY", 32'(RD_PTR_GRAY), 32'd0);
    check("midrst EMPTY", 32'(EMPTY), 32'd1);
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    check("midrst sync cleared", 32'(EMPTY), 32'd1);

    // Randomized traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) != 0, 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ctrl.md
Name: fifo_rd_ctrl

Overview:
- Read-side controller for the team's asynchronous FIFO; the counterpart of the write-domain memory and write logic.
- Runs entirely in the read clock domain.
- Synchronises the write pointer (Gray) into the read domain, generates EMPTY and the memory read address, and publishes the read pointer (Gray) back to the write side.
- Presents data through a one-entry registered output stage with a VALID/READY handshake.

Parameters:
DATA_WIDTH, 8, width of a FIFO word
ADDR_WIDTH, 3, memory address width; depth = 2^ADDR_WIDTH (8)
SYNC_STAGES, 2, flops in the write-pointer synchroniser (legal values 2 and above)

Ports:
R_CLK  input  1  read-domain clock; all state updates on its rising edge
R_RST  input  1  synchronous active-high reset, sampled on rising R_CLK
WQ_PTR_GRAY  input  ADDR_WIDTH+1  write pointer in Gray code, asynchronous to R_CLK
MEM_RD_DATA  input  DATA_WIDTH  combinational read data from FIFO memory at R_ADDR
DOUT_READY  input  1  downstream accepts DOUT this cycle
R_ADDR  output  ADDR_WIDTH  memory read address = rptr_bin[ADDR_WIDTH-1:0]
RD_PTR_GRAY  output  ADDR_WIDTH+1  registered read pointer, Gray, for write-side synchroniser
EMPTY  output  1  no unread word in memory as seen by read domain
LEVEL  output  ADDR_WIDTH+1  words in memory, excluding output stage (read-domain view)
DOUT  output  DATA_WIDTH  output data register
DOUT_VALID  output  1  DOUT holds a valid word

Behaviour:
- Clock and reset: one clock, R_CLK. R_RST is synchronous and active-high.
- Reset values: every output and internal register is 0, except EMPTY = 1. This covers rptr_bin, RD_PTR_GRAY, R_ADDR, all synchroniser flops, DOUT, DOUT_VALID and LEVEL.
- Reset mid-operation: any word in the output stage is discarded. The write side must be reset in the same window; this is a system-level requirement.
- Synchroniser:
  - WQ_PTR_GRAY passes through a chain of SYNC_STAGES flops; the last stage is wq_sync.
  - No other logic reads WQ_PTR_GRAY directly.
  - wbin_sync is the Gray-to-binary conversion of wq_sync (XOR prefix from MSB).
- Pointers:
  - rptr_bin is ADDR_WIDTH+1 bits and wraps modulo 2^(ADDR_WIDTH+1).
  - RD_PTR_GRAY is registered as next_bin ^ (next_bin >> 1), updated in the same edge as rptr_bin. It is never decoded combinationally from rptr_bin.
- Status outputs:
  - EMPTY = (RD_PTR_GRAY == wq_sync). It depends only on registers and has no direct path from asynchronous inputs.
  - LEVEL = (wbin_sync − rptr_bin) mod 2^(ADDR_WIDTH+1), range 0..2^ADDR_WIDTH.
- Pop condition: pop = !EMPTY && (!DOUT_VALID || DOUT_READY).
- On a pop edge:
  - DOUT <= MEM_RD_DATA (the word at the current R_ADDR).
  - DOUT_VALID <= 1.
  - rptr_bin <= rptr_bin + 1.
- Edges with no pop:
  - If DOUT_VALID && DOUT_READY: DOUT_VALID <= 0 and DOUT holds.
  - Otherwise all state holds.
- Handshake rules:
  - A transfer occurs on any edge where DOUT_VALID && DOUT_READY.
  - DOUT and DOUT_VALID are stable while DOUT_VALID && !DOUT_READY.
  - Simultaneous accept and pop gives back-to-back words with no bubble.
- Throughput: one word per R_CLK while not empty and DOUT_READY is high.
- Latency:
  - A write pointer change at the synchroniser input reaches wq_sync after SYNC_STAGES edges. EMPTY falls in that same cycle.
  - DOUT_VALID rises on the next edge.
  - Total: SYNC_STAGES+1 edges (3 by default).
- Full boundary:
  - Full is seen here as LEVEL = 2^ADDR_WIDTH, where the Gray codes differ in their two MSBs only.
  - No action is taken on full; the write side owns full detection.
- Wrap-around: R_ADDR goes 7→0 while the pointer MSB toggles. After 16 pops rptr_bin and RD_PTR_GRAY return to 0.
- Non-Gray input: a non-Gray step on WQ_PTR_GRAY is a write-side protocol violation. Behaviour is then undefined, but the block must not lock up once it is reset.

Test Plan:
1. Reset check: hold R_RST=1 for one edge with WQ_PTR_GRAY=0 -> EMPTY=1, DOUT_VALID=0, DOUT=0, R_ADDR=0, RD_PTR_GRAY=0, LEVEL=0.
2. Single word:
   - Stimulus: mem[0]=0xA5, DOUT_READY=1, WQ_PTR_GRAY 0→1 before edge k.
   - Required: EMPTY=0 after edge k+1; DOUT=0xA5, DOUT_VALID=1 after edge k+2; RD_PTR_GRAY=1, EMPTY=1.
3. Backpressure:
   - Stimulus: words 0x11, 0x22, 0x33 written, WQ_PTR_GRAY=0b0010 (binary 3), DOUT_READY=0.
   - While READY is low: DOUT=0x11 held, DOUT_VALID=1, LEVEL=2, R_ADDR=1.
   - Raise READY: 0x22 then 0x33 on consecutive edges, then DOUT_VALID=0.
4. Streaming and wrap:
   - Stimulus: 16 words 0x00..0x0F, with the writer keeping 1..8 ahead, DOUT_READY=1.
   - Required: all values in order with no gaps; R_ADDR wraps 7→0; RD_PTR_GRAY shows 0b1100 after the 8th pop and 0 after the 16th.
5. Full view: rptr_bin=0 and WQ_PTR_GRAY=0b1100 (binary 8) -> LEVEL=8, EMPTY=0 after 2 edges.
6. Reset mid-stream: assert R_RST for one edge while DOUT_VALID=1 and LEVEL=3 -> next cycle DOUT_VALID=0, LEVEL=0, RD_PTR_GRAY=0, EMPTY=1, synchroniser flops 0.
